// File: rtl/regfile_pkg.sv
// Shared constants for the register file, write-back selector and control unit.
// Register indices, bus-width defaults and the write-back source encoding.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   localparam logic [1:0] WB_DMEM  = 2'b00;
   localparam logic [1:0] WB_ALU   = 2'b01;
   localparam logic [1:0] WB_LINK  = 2'b10;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: $0 override, plus write-through forwarding
// when REGFILE_WB_BYPASS_EN is defined.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] raddr,
   input  logic [DATA_W-1:0] stored,
   input  logic              fwd_en,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

`ifndef REGFILE_WB_BYPASS_EN
   logic unused_fwd;
   assign unused_fwd = ^{fwd_en, waddr, wdata};
`endif

   always_comb begin
      rdata = stored;
`ifdef REGFILE_WB_BYPASS_EN
      // fwd_en already excludes $0 writes and writes under reset
      if (fwd_en && (raddr == waddr)) begin
         rdata = wdata;
      end
`endif
      if (raddr == ADDR_W'(REG_ZERO)) begin
         rdata = '0;
      end
   end

endmodule

// File: rtl/regfile_wb.sv
// 32 x 32 MIPS register file with two combinational read ports; $0 reads zero.
// Optional same-cycle write forwarding: define REGFILE_WB_BYPASS_EN.
module regfile_wb
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              wr_en;
   logic              fwd_en;

   // $0 is never written, so its flop holds its reset value forever
   assign wr_en  = we && (waddr != ADDR_W'(REG_ZERO));
   assign fwd_en = wr_en && rst_n;

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port1 (
      .raddr  (raddr1),
      .stored (regs_q[raddr1]),
      .fwd_en (fwd_en),
      .waddr  (waddr),
      .wdata  (wdata),
      .rdata  (rdata1)
   );

   regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port2 (
      .raddr  (raddr2),
      .stored (regs_q[raddr2]),
      .fwd_en (fwd_en),
      .waddr  (waddr),
      .wdata  (wdata),
      .rdata  (rdata2)
   );

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: stimulus pushes expected read data per cycle,
// a negedge monitor pops and compares against the live read ports.
module tb_regfile_wb;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [31:0] rdata1;
   logic [31:0] rdata2;

   regfile_wb dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .raddr1 (raddr1),
      .raddr2 (raddr2),
      .rdata1 (rdata1),
      .rdata2 (rdata2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] e1;
      logic [31:0] e2;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [32];
   int          checks   = 0;
   int          failures = 0;

`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   function automatic logic [31:0] expect_rd(input logic [4:0] ra);
      if (!rst_n || ra == 5'd0) return 32'h0;
      if (BYPASS && we && waddr != 5'd0 && waddr == ra) return wdata;
      return model[ra];
   endfunction

   // set inputs for this cycle and record what the read ports must show before the edge
   task automatic drive(input string name, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
      exp_t e;
      we = w; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2;
      e.name = name;
      e.e1 = expect_rd(r1);
      e.e2 = expect_rd(r2);
      sb.push_back(e);
   endtask

   task automatic step();
      logic rst_at_edge;
      @(posedge clk);
      rst_at_edge = rst_n;
      if (rst_at_edge && we && waddr != 5'd0) model[waddr] = wdata;
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (rdata1 !== e.e1) begin
            failures++;
            $display("FAIL %s rdata1 raddr1=%0d got=%h exp=%h", e.name, raddr1, rdata1, e.e1);
         end
         checks++;
         if (rdata2 !== e.e2) begin
            failures++;
            $display("FAIL %s rdata2 raddr2=%0d got=%h exp=%h", e.name, raddr2, rdata2, e.e2);
         end
      end
   end

   initial begin
      exp_t e;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
      @(posedge clk); #1;
      drive("reset_state", 1'b1, 5'd7, 32'h5555_AAAA, 5'd7, 5'd31);
      step();
      rst_n = 1'b1;
      drive("after_reset", 1'b0, 5'd0, 32'h0, 5'd7, 5'd1);
      step();

      // async reset clear of a preloaded register, with a write pending during reset
      drive("preload_r5", 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd0);
      step();
      drive("r5_loaded", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      step();
      raddr1 = 5'd5; raddr2 = 5'd5; we = 1'b1; waddr = 5'd5; wdata = 32'hCAFE_F00D;
      #2;
      rst_n = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      e.name = "reset_async_clear"; e.e1 = 32'h0; e.e2 = 32'h0;
      sb.push_back(e);
      step();
      drive("reset_write_lost", 1'b1, 5'd5, 32'hCAFE_F00D, 5'd5, 5'd5);
      step();
      rst_n = 1'b1;
      drive("post_reset_r5", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      step();

      drive("write_r8", 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0);
      step();
      drive("read_r8_both", 1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
      step();

      drive("r0_write_pre", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      step();
      drive("r0_write_post", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      step();

      drive("r30_preload", 1'b1, 5'd30, 32'h3030_3030, 5'd0, 5'd0);
      step();
      drive("jal_write", 1'b1, 5'd31, 32'h0040_0008, 5'd30, 5'd31);
      step();
      drive("jal_read", 1'b0, 5'd0, 32'h0, 5'd30, 5'd31);
      step();

      drive("r9_old", 1'b1, 5'd9, 32'h11, 5'd0, 5'd0);
      step();
      drive("r9_same_cycle", 1'b1, 5'd9, 32'h22, 5'd9, 5'd9);
      step();
      drive("r9_after_edge", 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
      step();

      drive("r12_preload", 1'b1, 5'd12, 32'h0000_5A5A, 5'd0, 5'd0);
      step();
      for (int i = 0; i < 10; i++) begin
         drive("we0_hold", 1'b0, 5'd12, 32'h0000_ABCD, 5'd12, 5'd12);
         step();
      end

      for (int i = 1; i < 32; i++) begin
         drive("sweep_write", 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0);
         step();
      end
      for (int i = 0; i < 32; i++) begin
         drive("sweep_read", 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
         step();
      end

      for (int i = 0; i < 300; i++) begin
         logic [4:0] wa;
         logic [4:0] r1;
         wa = 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         drive("random", 1'($urandom_range(0, 1)), wa, $urandom(), r1,
               5'($urandom_range(0, 31)));
         step();
      end

      we = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle 31-instruction MIPS core.
- Sits directly downstream of the write-back source selector and consumes its selected write data: lw result, ALU result, or PC+8/link value for jal.
- Provides two combinational read ports to the decode/ALU operand path.
- Register $0 is hardwired to zero.

Parameters:
DATA_W, 32, width of each register and of the read/write data buses
ADDR_W, 5, register index width; register count NUM_REGS = 2**ADDR_W (32)

Ports:
clk  input  1  core clock; all writes occur on its rising edge
rst_n  input  1  asynchronous, active-low reset
we  input  1  write enable from control unit (high for lw, ALU-writing instructions, jal)
waddr  input  ADDR_W  destination register index (rd, rt, or 31 for jal, chosen upstream)
wdata  input  DATA_W  write-back data from the write-back source selector
raddr1  input  ADDR_W  read port 1 index (rs)
raddr2  input  ADDR_W  read port 2 index (rt)
rdata1  output  DATA_W  read port 1 data
rdata2  output  DATA_W  read port 2 data

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous and active-low.
- Storage: NUM_REGS registers of DATA_W bits.
- Reset:
  - On rst_n falling (asserted low), all 32 registers clear to 0 immediately, independent of clk.
  - While rst_n is low, writes are ignored and rdata1/rdata2 read 0.
  - Release is synchronous to the design only in the sense that the first write may land on the first rising clk edge with rst_n high.
- Write:
  - On a rising clk edge with rst_n high, we=1 and waddr!=0: reg[waddr] <= wdata.
  - we=0: no register changes.
  - waddr=0 with we=1: write discarded; reg[0] stays 0 at all times.
- Read:
  - Purely combinational, zero-cycle latency.
  - rdataN = (raddrN==0) ? 0 : reg[raddrN].
- Same-address timing (default build, no bypass):
  - A read of the address being written in the same cycle returns the pre-edge (old) value.
  - The new value is visible after the rising edge.
- Both read ports may address the same register simultaneously; both return identical data.
- No X propagation: every register has a defined reset value, and all addresses are in range (5-bit index covers all 32 entries).
- Reset asserted mid-cycle while we=1: reset wins; the register reads 0 and the pending write is lost.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Internal write-through forwarding per read port.
  - If we=1, waddr!=0 and raddrN==waddr, rdataN = wdata combinationally in the same cycle, before the edge.
  - $0 is never bypassed.
  - Intended for a future pipelined core in which write-back and decode overlap.
- Undefined: forwarding logic is absent and reads return stored values only, as described above.

Decomposition:
- Shared package regfile_pkg:
  - REG_ZERO = 5'd0
  - REG_RA = 5'd31 (jal link register)
  - DATA_W/ADDR_W defaults
  - write-back select encoding constants WB_DMEM=2'b00, WB_ALU=2'b01, WB_LINK=2'b10, shared with the write-back selector and control unit.
- One natural sub-module: regfile_rd_port.
  - Instantiated twice, one per read port.
  - Contains the zero-index override and, under REGFILE_WB_BYPASS_EN, the forwarding compare/mux.
- The storage array and write logic stay in regfile_wb.

Test Plan:
- Reset clear: preload r5=0x1234_5678, pulse rst_n low between clock edges -> rdata1 (raddr1=5) goes 0 immediately, without waiting for a clk edge.
- Basic write/read: we=1, waddr=8, wdata=0xDEAD_BEEF, one edge -> raddr1=8 and raddr2=8 both read 0xDEAD_BEEF.
- $0 protection: we=1, waddr=0, wdata=0xFFFF_FFFF -> raddr1=0 reads 0 before and after the edge.
- jal link write: we=1, waddr=31, wdata=0x0040_0008 -> raddr2=31 reads 0x0040_0008 next cycle, and r30 is unchanged.
- Same-cycle read/write on r9 (old value 0x11, wdata=0x22):
  - Without the macro: rdata1 = 0x11 before the edge, 0x22 after.
  - With REGFILE_WB_BYPASS_EN: rdata1 = 0x22 before the edge.
- we=0 hold: drive waddr=12, wdata=0xABCD over 10 cycles with we=0 -> r12 keeps its prior value. Then an all-registers sweep (write i*0x0101_0101 to r1..r31) reads back exactly.
